udp_tx_stream_arbiter: RTL and testbench

Packet-granular, round-robin arbiter that merges `CHANNELS` independent UDP payload AXI-Stream sources into the single `udp_tx_axis_*` input of the 100G UDP engine. It tags each packet with its source's connection ID and enforces a maximum packet length by truncation. It sits in the TX clock domain between the application channels and the engine core. It generalises the engine's single-source TX port to N sources with a parametrised width.

---
 rtl/udp_tx_stream_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_udp_tx_stream_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx_stream_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : udp_tx_stream_arbiter
//  Purpose  : Packet-granular round-robin merge of CHANNELS UDP payload
//             AXI-Stream sources into the single TX input of the UDP engine.
//             Each packet is tagged with its source connection ID and is
//             truncated (forced tlast, tail discarded) at MAX_BEATS beats.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    tx_axis_aclk / tx_axis_aresetn : clock, async active-low reset
//    s_axis_*            : per-channel sources, channel i in slice i
//    s_axis_connection_id: per-channel connection ID, sampled at grant
//    m_axis_*            : merged stream towards the engine
//    m_axis_connection_id: ID of the packet currently being forwarded
//    truncate_pulse      : per-channel strobe on the forced-tlast handshake
//  Build option
//    UDP_TX_ARB_OUT_REG_EN : when defined, a 2-entry skid buffer registers
//                            all m_axis_* outputs (+1 cycle latency).
// ============================================================================
module udp_tx_stream_arbiter #(
    parameter int DATA_WIDTH    = 512,
    parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
    parameter int CHANNELS      = 4,
    parameter int CONN_ID_WIDTH = 18,
    parameter int MAX_BEATS     = 24
) (
    input  logic                              tx_axis_aclk,
    input  logic                              tx_axis_aresetn,
    input  logic [CHANNELS*DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [CHANNELS*KEEP_WIDTH-1:0]    s_axis_tkeep,
    input  logic [CHANNELS-1:0]               s_axis_tvalid,
    input  logic [CHANNELS-1:0]               s_axis_tlast,
    output logic [CHANNELS-1:0]               s_axis_tready,
    input  logic [CHANNELS*CONN_ID_WIDTH-1:0] s_axis_connection_id,
    output logic [DATA_WIDTH-1:0]             m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]             m_axis_tkeep,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    input  logic                              m_axis_tready,
    output logic [CONN_ID_WIDTH-1:0]          m_axis_connection_id,
    output logic [CHANNELS-1:0]               truncate_pulse
);

    localparam int IDX_W = $clog2(CHANNELS);
    localparam int CNT_W = $clog2(MAX_BEATS);
    localparam logic [IDX_W-1:0] c_last_ch   = IDX_W'(CHANNELS - 1);
    localparam logic [CNT_W-1:0] c_last_beat = CNT_W'(MAX_BEATS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t                   r_state;
    logic [IDX_W-1:0]         r_grant;
    logic [IDX_W-1:0]         r_last_grant;
    logic [CONN_ID_WIDTH-1:0] r_conn_id;
    logic [CNT_W-1:0]         r_beat_cnt;

    logic [DATA_WIDTH-1:0]    w_sel_data;
    logic [KEEP_WIDTH-1:0]    w_sel_keep;
    logic                     w_sel_valid;
    logic                     w_sel_last;
    logic                     w_at_max;
    logic [IDX_W-1:0]         w_rr_idx;
    logic [IDX_W-1:0]         w_next_grant;
    logic                     w_any_valid;

    logic [DATA_WIDTH-1:0]    w_core_data;
    logic [KEEP_WIDTH-1:0]    w_core_keep;
    logic                     w_core_valid;
    logic                     w_core_last;
    logic                     w_core_ready;
    logic                     w_core_hs;
    logic                     w_trunc_fire;

    // Granted channel's beat
    assign w_sel_data  = s_axis_tdata[r_grant*DATA_WIDTH +: DATA_WIDTH];
    assign w_sel_keep  = s_axis_tkeep[r_grant*KEEP_WIDTH +: KEEP_WIDTH];
    assign w_sel_valid = s_axis_tvalid[r_grant];
    assign w_sel_last  = s_axis_tlast[r_grant];
    assign w_at_max    = (r_beat_cnt == c_last_beat);
    assign w_any_valid = |s_axis_tvalid;

    // Round-robin search starting at last_grant+1. Iterating from the
    // farthest candidate down to the nearest lets the nearest valid win.
    always_comb begin
        w_rr_idx     = '0;
        w_next_grant = r_last_grant;
        for (int k = CHANNELS; k >= 1; k--) begin
            w_rr_idx = IDX_W'((int'(r_last_grant) + k) % CHANNELS);
            if (s_axis_tvalid[w_rr_idx]) begin
                w_next_grant = w_rr_idx;
            end
        end
    end

    // Data path is combinational only in FWD; IDLE presents zeros so the
    // first beat appears one cycle after the grant.
    assign w_core_valid = (r_state == ST_FWD) && w_sel_valid;
    assign w_core_data  = (r_state == ST_FWD) ? w_sel_data : '0;
    assign w_core_keep  = (r_state == ST_FWD) ? w_sel_keep : '0;
    assign w_core_last  = (r_state == ST_FWD) && (w_sel_last || w_at_max);
    assign w_core_hs    = w_core_valid && w_core_ready;
    assign w_trunc_fire = w_core_hs && w_at_max && !w_sel_last;

    always_comb begin
        s_axis_tready  = '0;
        truncate_pulse = '0;
        if (r_state == ST_FWD) begin
            s_axis_tready[r_grant] = w_core_ready;
        end else if (r_state == ST_DROP) begin
            s_axis_tready[r_grant] = 1'b1;
        end
        truncate_pulse[r_grant] = w_trunc_fire;
    end

    always_ff @(posedge tx_axis_aclk or negedge tx_axis_aresetn) begin
        if (!tx_axis_aresetn) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_last_grant <= c_last_ch;
            r_conn_id    <= '0;
            r_beat_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_valid) begin
                        r_grant    <= w_next_grant;
                        r_conn_id  <= s_axis_connection_id[w_next_grant*CONN_ID_WIDTH +: CONN_ID_WIDTH];
                        r_beat_cnt <= '0;
                        r_state    <= ST_FWD;
                    end
                end
                ST_FWD: begin
                    if (w_core_hs) begin
                        if (w_sel_last) begin
                            r_last_grant <= r_grant;
                            r_state      <= ST_IDLE;
                        end else if (w_at_max) begin
                            r_state <= ST_DROP;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 1'b1;
                        end
                    end
                end
                ST_DROP: begin
                    if (w_sel_valid && w_sel_last) begin
                        r_last_grant <= r_grant;
                        r_state      <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef UDP_TX_ARB_OUT_REG_EN
    // Two-entry FIFO: upstream ready depends only on the registered fill
    // level, which breaks the m_axis_tready -> s_axis_tready path while
    // still sustaining one beat per cycle.
    logic [DATA_WIDTH-1:0]    r_buf_data [2];
    logic [KEEP_WIDTH-1:0]    r_buf_keep [2];
    logic [CONN_ID_WIDTH-1:0] r_buf_id   [2];
    logic [1:0]               r_buf_last;
    logic                     r_wr_ptr;
    logic                     r_rd_ptr;
    logic [1:0]               r_count;
    logic                     w_pop;

    assign w_core_ready = (r_count != 2'd2);
    assign w_pop        = (r_count != 2'd0) && m_axis_tready;

    always_ff @(posedge tx_axis_aclk or negedge tx_axis_aresetn) begin
        if (!tx_axis_aresetn) begin
            for (int i = 0; i < 2; i++) begin
                r_buf_data[i] <= '0;
                r_buf_keep[i] <= '0;
                r_buf_id[i]   <= '0;
            end
            r_buf_last <= '0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
        end else begin
            if (w_core_hs) begin
                r_buf_data[r_wr_ptr] <= w_core_data;
                r_buf_keep[r_wr_ptr] <= w_core_keep;
                r_buf_id[r_wr_ptr]   <= r_conn_id;
                r_buf_last[r_wr_ptr] <= w_core_last;
                r_wr_ptr             <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_core_hs} - {1'b0, w_pop};
        end
    end

    assign m_axis_tdata         = r_buf_data[r_rd_ptr];
    assign m_axis_tkeep         = r_buf_keep[r_rd_ptr];
    assign m_axis_tlast         = (r_count != 2'd0) && r_buf_last[r_rd_ptr];
    assign m_axis_tvalid        = (r_count != 2'd0);
    assign m_axis_connection_id = r_buf_id[r_rd_ptr];
`else
    assign w_core_ready         = m_axis_tready;
    assign m_axis_tdata         = w_core_data;
    assign m_axis_tkeep         = w_core_keep;
    assign m_axis_tlast         = w_core_last;
    assign m_axis_tvalid        = w_core_valid;
    assign m_axis_connection_id = r_conn_id;
`endif

endmodule
`default_nettype wire

// File: tb/tb_udp_tx_stream_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_udp_tx_stream_arbiter
//  Purpose  : Scoreboard bench for udp_tx_stream_arbiter (CHANNELS=4,
//             DATA_WIDTH=32, MAX_BEATS=4). Directed packets are queued per
//             source; expected output beats are queued in hand-chosen order
//             and popped by an independent monitor.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_udp_tx_stream_arbiter;

    localparam int DW = 32;
    localparam int KW = 4;
    localparam int CH = 4;
    localparam int IW = 18;
    localparam int MB = 4;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
    } beat_t;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
        logic [IW-1:0] id;
        logic [CH-1:0] tr;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [CH*DW-1:0]  s_axis_tdata;
    logic [CH*KW-1:0]  s_axis_tkeep;
    logic [CH-1:0]     s_axis_tvalid;
    logic [CH-1:0]     s_axis_tlast;
    logic [CH-1:0]     s_axis_tready;
    logic [CH*IW-1:0]  s_axis_connection_id;
    logic [DW-1:0]     m_axis_tdata;
    logic [KW-1:0]     m_axis_tkeep;
    logic              m_axis_tvalid;
    logic              m_axis_tlast;
    logic              m_axis_tready;
    logic [IW-1:0]     m_axis_connection_id;
    logic [CH-1:0]     truncate_pulse;

    beat_t         src_q [CH][$];
    logic [IW-1:0] src_id [CH];
    exp_t          exp_q [$];
    int            hs_cyc [$];
    int            n_chk = 0;
    int            n_err = 0;
    int            cyc = 0;
    bit            tog_rdy = 1'b0;

    always #5 clk = ~clk;

    udp_tx_stream_arbiter #(
        .DATA_WIDTH    (DW),
        .KEEP_WIDTH    (KW),
        .CHANNELS      (CH),
        .CONN_ID_WIDTH (IW),
        .MAX_BEATS     (MB)
    ) dut (
        .tx_axis_aclk         (clk),
        .tx_axis_aresetn      (rst_n),
        .s_axis_tdata         (s_axis_tdata),
        .s_axis_tkeep         (s_axis_tkeep),
        .s_axis_tvalid        (s_axis_tvalid),
        .s_axis_tlast         (s_axis_tlast),
        .s_axis_tready        (s_axis_tready),
        .s_axis_connection_id (s_axis_connection_id),
        .m_axis_tdata         (m_axis_tdata),
        .m_axis_tkeep         (m_axis_tkeep),
        .m_axis_tvalid        (m_axis_tvalid),
        .m_axis_tlast         (m_axis_tlast),
        .m_axis_tready        (m_axis_tready),
        .m_axis_connection_id (m_axis_connection_id),
        .truncate_pulse       (truncate_pulse)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    function automatic logic [DW-1:0] mk_data(input int ch, input int pkt, input int b);
        return {8'(ch), 8'(pkt), 8'(b), 8'h5A};
    endfunction

    function automatic logic [KW-1:0] mk_keep(input int b);
        return 4'hF ^ 4'(b & 3);
    endfunction

    task automatic src_pkt(input int ch, input int pkt, input int nb, input logic [IW-1:0] id);
        beat_t bt;
        src_id[ch] = id;
        for (int b = 0; b < nb; b++) begin
            bt.d = mk_data(ch, pkt, b);
            bt.k = mk_keep(b);
            bt.l = (b == nb - 1);
            src_q[ch].push_back(bt);
        end
    endtask

    // Expected output for a packet of nb source beats: at most MB beats
    // leave, the MB-th carrying a forced tlast and the truncate strobe.
    task automatic exp_pkt(input int ch, input int pkt, input int nb, input logic [IW-1:0] id,
                           input int n_exp);
        exp_t e;
        for (int b = 0; b < n_exp; b++) begin
            e.d  = mk_data(ch, pkt, b);
            e.k  = mk_keep(b);
            e.l  = (b == nb - 1) || (b == MB - 1);
            e.id = id;
            e.tr = (nb > MB && b == MB - 1) ? 4'(1 << ch) : 4'h0;
            exp_q.push_back(e);
        end
    endtask

    function automatic bit src_busy();
        for (int c = 0; c < CH; c++) begin
            if (src_q[c].size() != 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || src_busy()) && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (n >= budget) begin
            n_chk++;
            n_err++;
            $display("FAIL %s_timeout: got %0d expected beats pending, expected 0", name, exp_q.size());
            exp_q.delete();
            for (int c = 0; c < CH; c++) src_q[c].delete();
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        for (int c = 0; c < CH; c++) src_q[c].delete();
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Cycle counter
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Source driver: handshakes sampled mid-cycle, next beat presented after the edge
    initial begin : driver
        logic [CH-1:0] hs;
        s_axis_tdata = '0;
        s_axis_tkeep = '0;
        s_axis_tvalid = '0;
        s_axis_tlast = '0;
        s_axis_connection_id = '0;
        m_axis_tready = 1'b1;
        for (int c = 0; c < CH; c++) src_id[c] = '0;
        forever begin
            @(negedge clk);
            hs = s_axis_tvalid & s_axis_tready;
            @(posedge clk);
            #1;
            if (tog_rdy) m_axis_tready = ~m_axis_tready;
            for (int c = 0; c < CH; c++) begin
                if (hs[c] && src_q[c].size() > 0) void'(src_q[c].pop_front());
                s_axis_connection_id[c*IW +: IW] = src_id[c];
                if (src_q[c].size() > 0) begin
                    s_axis_tdata[c*DW +: DW] = src_q[c][0].d;
                    s_axis_tkeep[c*KW +: KW] = src_q[c][0].k;
                    s_axis_tlast[c]          = src_q[c][0].l;
                    s_axis_tvalid[c]         = 1'b1;
                end else begin
                    s_axis_tdata[c*DW +: DW] = '0;
                    s_axis_tkeep[c*KW +: KW] = '0;
                    s_axis_tlast[c]          = 1'b0;
                    s_axis_tvalid[c]         = 1'b0;
                end
            end
        end
    end

    // Monitor / scoreboard
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("single_ready", 64'($countones(s_axis_tready) > 1), 64'(0));
                if (m_axis_tvalid && m_axis_tready) begin
                    hs_cyc.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_err++;
                        $display("FAIL unexpected_beat: got data 0x%0h, expected no beat", m_axis_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_payload", 64'({m_axis_tdata, m_axis_tkeep, m_axis_tlast}),
                            64'({e.d, e.k, e.l}));
                        chk("beat_id_trunc", 64'({m_axis_connection_id, truncate_pulse}),
                            64'({e.id, e.tr}));
                    end
                end else begin
                    chk("trunc_without_beat", 64'(truncate_pulse), 64'(0));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int t_start;
        int n;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_ctrl", 64'({m_axis_tvalid, m_axis_tlast, s_axis_tready, truncate_pulse, m_axis_tkeep}), 64'(0));
        chk("reset_data", 64'(m_axis_tdata), 64'(0));
        chk("reset_id", 64'(m_axis_connection_id), 64'(0));
        rst_n = 1'b1;

        // T1: channel 2 alone, 3 beats, ID 0x155
        hs_cyc.delete();
        @(negedge clk);
        src_pkt(2, 1, 3, 18'h155);
        exp_pkt(2, 1, 3, 18'h155, 3);
        t_start = cyc + 1;
        @(negedge clk);
        chk("t1_grant_cycle_tvalid", 64'(m_axis_tvalid), 64'(0));
        chk("t1_grant_cycle_tready", 64'(s_axis_tready), 64'(0));
        drain("t1", 30);
        chk("t1_beats", 64'(hs_cyc.size()), 64'(3));
        if (hs_cyc.size() == 3) chk("t1_total_cycles", 64'(hs_cyc[2] - t_start + 1), 64'(4));

        // T2: all channels, two 1-beat packets each, order 0,1,2,3,0,1,2,3
        do_reset();
        hs_cyc.delete();
        @(negedge clk);
        for (int c = 0; c < CH; c++) begin
            src_pkt(c, 0, 1, 18'(16'h100 + c));
            src_pkt(c, 1, 1, 18'(16'h100 + c));
        end
        for (int p = 0; p < 2; p++) begin
            for (int c = 0; c < CH; c++) exp_pkt(c, p, 1, 18'(16'h100 + c), 1);
        end
        drain("t2", 60);
        chk("t2_beats", 64'(hs_cyc.size()), 64'(8));
        if (hs_cyc.size() == 8) begin
            for (int i = 0; i < 7; i++) chk("t2_gap", 64'(hs_cyc[i+1] - hs_cyc[i]), 64'(2));
            chk("t2_ch0_period", 64'(hs_cyc[4] - hs_cyc[0]), 64'(8));
        end

        // T3: channel 1 sends 7 beats (truncated to 4), channel 2 waits
        hs_cyc.delete();
        @(negedge clk);
        src_pkt(1, 2, 7, 18'h0AB1);
        src_pkt(2, 2, 1, 18'h20002);
        exp_pkt(1, 2, 7, 18'h0AB1, 4);
        exp_pkt(2, 2, 1, 18'h20002, 1);
        drain("t3", 40);
        chk("t3_beats", 64'(hs_cyc.size()), 64'(5));
        if (hs_cyc.size() == 5) chk("t3_drop_then_grant", 64'(hs_cyc[4] - hs_cyc[3]), 64'(5));

        // T4: exactly MAX_BEATS beats on channel 0, no truncation
        @(negedge clk);
        src_pkt(0, 3, 4, 18'h3FFFF);
        exp_pkt(0, 3, 4, 18'h3FFFF, 4);
        drain("t4", 30);

        // T5: tready toggling; channel 2 (4 beats) then channel 0 (1 beat)
        hs_cyc.delete();
        tog_rdy = 1'b1;
        @(negedge clk);
        src_pkt(2, 4, 4, 18'h01234);
        src_pkt(0, 4, 1, 18'h00777);
        exp_pkt(2, 4, 4, 18'h01234, 4);
        exp_pkt(0, 4, 1, 18'h00777, 1);
        drain("t5", 60);
        tog_rdy = 1'b0;
        @(posedge clk);
        #2;
        m_axis_tready = 1'b1;
        chk("t5_beats", 64'(hs_cyc.size()), 64'(5));
        if (hs_cyc.size() == 5) chk("t5_span", 64'(hs_cyc[3] - hs_cyc[0]), 64'(6));

        // T6: reset during beat 2 of a channel 3 packet
        hs_cyc.delete();
        @(negedge clk);
        src_pkt(3, 5, 3, 18'h00ABC);
        exp_pkt(3, 5, 3, 18'h00ABC, 1);
        n = 0;
        while (hs_cyc.size() < 1 && n < 20) begin
            @(posedge clk);
            n++;
        end
        chk("t6_first_beat_seen", 64'(hs_cyc.size()), 64'(1));
        #2;
        chk("t6_pre_reset_valid", 64'(m_axis_tvalid), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("t6_rst_ctrl", 64'({m_axis_tvalid, m_axis_tlast, s_axis_tready, truncate_pulse, m_axis_tkeep}), 64'(0));
        chk("t6_rst_data", 64'(m_axis_tdata), 64'(0));
        chk("t6_rst_id", 64'(m_axis_connection_id), 64'(0));
        src_q[3].delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        hs_cyc.delete();
        @(negedge clk);
        src_pkt(1, 6, 1, 18'h00011);
        src_pkt(0, 6, 1, 18'h00010);
        exp_pkt(0, 6, 1, 18'h00010, 1);
        exp_pkt(1, 6, 1, 18'h00011, 1);
        drain("t6", 30);
        chk("t6_beats", 64'(hs_cyc.size()), 64'(2));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
